db_mac_seq: RTL and testbench



---
 rtl/db_mac_seq.sv | 152 +++++++++++++++
 tb/tb_db_mac_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/db_mac_seq.sv
// Sequencer plus signed fixed-point MAC sitting on the data bank ports:
// reads A[base_a+i] and B[base_b+i], accumulates the products, writes sat(sum) to dst.
module db_mac_seq #(
  parameter int W     = 24,
  parameter int FRAC  = 12,
  parameter int ADDRW = 6,
  parameter int LENW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LENW-1:0]  len,
  input  logic [ADDRW-1:0] base_a,
  input  logic [ADDRW-1:0] base_b,
  input  logic [ADDRW-1:0] dst,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] db_raddr_a,
  output logic [ADDRW-1:0] db_raddr_b,
  input  logic [W-1:0]     db_rdata_a,
  input  logic [W-1:0]     db_rdata_b,
  output logic             db_we,
  output logic [ADDRW-1:0] db_waddr,
  output logic [W-1:0]     db_wdata
);

  localparam int PW   = 2*W - FRAC;
  localparam int ACCW = PW + LENW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WRITE} state_t;

  state_t                  state, state_nx;
  logic [LENW-1:0]         len_q, i_q;
  logic [ADDRW-1:0]        base_a_q, base_b_q, dst_q;
  logic [ADDRW-1:0]        raddr_a_q, raddr_b_q;
  logic [ADDRW-1:0]        addr_a_cur, addr_b_cur;
  logic signed [W-1:0]     opa_p0, opb_p0;
  logic signed [2*W-1:0]   opa_ext_p0, opb_ext_p0, prod_full_p0;
  logic signed [PW-1:0]    prod_p1;
  logic                    vld_p1;
  logic signed [ACCW-1:0]  acc_p2;
  logic signed [ACCW-1:0]  prod_ext_p1;

  // Arithmetic shift right by FRAC, rounding toward minus infinity.
  function automatic logic signed [PW-1:0] shr_floor(input logic signed [2*W-1:0] x);
    return x[2*W-1:FRAC];
  endfunction

  // Clamp the wide accumulator into a W-bit signed word.
  function automatic logic [W-1:0] sat(input logic signed [ACCW-1:0] x);
    logic [ACCW-W:0] hi;
    hi = x[ACCW-1:W-1];
    if (!x[ACCW-1] && (|hi))
      return {1'b0, {(W-1){1'b1}}};
    else if (x[ACCW-1] && !(&hi))
      return {1'b1, {(W-1){1'b0}}};
    else
      return x[W-1:0];
  endfunction

  assign addr_a_cur   = base_a_q + ADDRW'(i_q);
  assign addr_b_cur   = base_b_q + ADDRW'(i_q);

  // Stage p0: operands arrive from the bank in the same cycle as the address
  assign opa_p0       = db_rdata_a;
  assign opb_p0       = db_rdata_b;
  assign opa_ext_p0   = {{W{opa_p0[W-1]}}, opa_p0};
  assign opb_ext_p0   = {{W{opb_p0[W-1]}}, opb_p0};
  assign prod_full_p0 = opa_ext_p0 * opb_ext_p0;

  // Stage p1 -> p2: registered product feeds the accumulator
  assign prod_ext_p1  = $signed({{(ACCW-PW){prod_p1[PW-1]}}, prod_p1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      i_q       <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      dst_q     <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      prod_p1   <= '0;
      vld_p1    <= 1'b0;
      acc_p2    <= '0;
    end else begin
      state  <= state_nx;
      vld_p1 <= (state == RUN);
      if (state == RUN)
        prod_p1 <= shr_floor(prod_full_p0);

      if (state == IDLE && start)
        acc_p2 <= '0;
      else if (vld_p1)
        acc_p2 <= acc_p2 + prod_ext_p1;

      case (state)
        IDLE: begin
          if (start) begin
            dst_q <= dst;
            if (len != '0) begin
              len_q    <= len;
              base_a_q <= base_a;
              base_b_q <= base_b;
              i_q      <= '0;
            end
          end
        end
        RUN: begin
          i_q       <= i_q + LENW'(1);
          raddr_a_q <= addr_a_cur;
          raddr_b_q <= addr_b_cur;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    db_we      = 1'b0;
    db_waddr   = '0;
    db_wdata   = '0;
    db_raddr_a = raddr_a_q;
    db_raddr_b = raddr_b_q;
    case (state)
      IDLE: begin
        if (start)
          state_nx = (len == '0) ? WRITE : RUN;
      end
      RUN: begin
        db_raddr_a = addr_a_cur;
        db_raddr_b = addr_b_cur;
        if (i_q == len_q - LENW'(1))
          state_nx = DRAIN;
      end
      DRAIN: state_nx = WRITE;
      WRITE: begin
        state_nx = IDLE;
        done     = 1'b1;
        db_we    = 1'b1;
        db_waddr = dst_q;
        db_wdata = sat(acc_p2);
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_db_mac_seq.sv
// Directed bench for db_mac_seq with a behavioural 64-word data bank.
module tb_db_mac_seq;

  logic        clk, rst_n, start;
  logic [4:0]  len;
  logic [5:0]  base_a, base_b, dst;
  logic        busy, done, db_we;
  logic [5:0]  db_raddr_a, db_raddr_b, db_waddr;
  logic [23:0] db_rdata_a, db_rdata_b, db_wdata;

  logic [23:0] mem [64];

  int n_checks = 0;
  int n_err    = 0;

  int          we_cnt, done_cnt, busy_cnt, lat;
  logic [23:0] wd;
  logic [5:0]  wa;
  logic        done_ok;
  logic [5:0]  ra_log [40];
  logic [5:0]  rb_log [40];
  logic [5:0]  pre_ra;
  int          rst_we;

  db_mac_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .base_a(base_a), .base_b(base_b), .dst(dst),
    .busy(busy), .done(done),
    .db_raddr_a(db_raddr_a), .db_raddr_b(db_raddr_b),
    .db_rdata_a(db_rdata_a), .db_rdata_b(db_rdata_b),
    .db_we(db_we), .db_waddr(db_waddr), .db_wdata(db_wdata)
  );

  assign db_rdata_a = mem[db_raddr_a];
  assign db_rdata_b = mem[db_raddr_b];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then watch 40 cycles; n=1 is the first cycle after accept.
  task automatic run_op(input logic [4:0] l, input logic [5:0] ba, input logic [5:0] bb,
                        input logic [5:0] d, input bit poke);
    we_cnt = 0; done_cnt = 0; busy_cnt = 0; lat = -1; wd = '0; wa = '0; done_ok = 1'b0;
    @(negedge clk);
    start = 1'b1; len = l; base_a = ba; base_b = bb; dst = d;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      ra_log[n-1] = db_raddr_a;
      rb_log[n-1] = db_raddr_b;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (db_we) begin
        we_cnt++;
        if (lat < 0) begin
          lat = n; wd = db_wdata; wa = db_waddr; done_ok = done;
        end
      end
      if (poke && n == 2) begin
        start = 1'b1; len = 5'd1; base_a = 6'd0; base_b = 6'd0; dst = 6'd31;
      end
      if (poke && n == 3) start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; base_a = '0; base_b = '0; dst = '0;
    for (int k = 0; k < 64; k++) mem[k] = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   busy,       0);
    check("rst_done",   done,       0);
    check("rst_we",     db_we,      0);
    check("rst_waddr",  db_waddr,   0);
    check("rst_wdata",  db_wdata,   0);
    check("rst_raddra", db_raddr_a, 0);
    check("rst_raddrb", db_raddr_b, 0);
    rst_n = 1'b1;

    // 1.0*1.0 + 2.0*1.0 = 3.0
    mem[0] = 24'd4096; mem[1] = 24'd8192; mem[8] = 24'd4096; mem[9] = 24'd4096;
    run_op(5'd2, 6'd0, 6'd8, 6'd20, 1'b0);
    check("basic_we_cnt", we_cnt,   1);
    check("basic_waddr",  wa,       20);
    check("basic_wdata",  wd,       24'h003000);
    check("basic_done",   done_ok,  1);
    check("basic_dcnt",   done_cnt, 1);
    check("basic_lat",    lat,      4);

    // -1.0 * 1.5 = -1.5
    mem[0] = 24'hFFF000; mem[1] = 24'd6144;
    run_op(5'd1, 6'd0, 6'd1, 6'd5, 1'b0);
    check("sign_wdata", wd,  24'hFFE800);
    check("sign_waddr", wa,  5);
    check("sign_lat",   lat, 3);

    for (int k = 0; k < 4; k++) begin
      mem[k] = 24'h7FFFFF; mem[8+k] = 24'h800000;
    end
    run_op(5'd4, 6'd0, 6'd0, 6'd12, 1'b0);
    check("sat_pos", wd, 24'h7FFFFF);
    run_op(5'd4, 6'd0, 6'd8, 6'd12, 1'b0);
    check("sat_neg", wd, 24'h800000);

    pre_ra = db_raddr_a;
    run_op(5'd0, 6'd3, 6'd4, 6'd7, 1'b0);
    check("len0_lat",   lat,       1);
    check("len0_wdata", wd,        0);
    check("len0_waddr", wa,        7);
    check("len0_done",  done_ok,   1);
    check("len0_busy",  busy_cnt,  1);
    check("len0_raddr", ra_log[0], pre_ra);

    // A reads 63,0,1 = 2,-1,3 ; B reads 62,63,0 = 1,2,-1 ; sum = 2-2-3 = -3
    mem[62] = 24'd4096; mem[63] = 24'd8192; mem[0] = 24'hFFF000; mem[1] = 24'd12288;
    run_op(5'd3, 6'd63, 6'd62, 6'd40, 1'b0);
    check("wrap_ra0", ra_log[0], 63);
    check("wrap_ra1", ra_log[1], 0);
    check("wrap_ra2", ra_log[2], 1);
    check("wrap_rb0", rb_log[0], 62);
    check("wrap_rb1", rb_log[1], 63);
    check("wrap_rb2", rb_log[2], 0);
    check("wrap_wdata", wd, 24'hFFD000);

    // 1*1 + 1*2 + 1*(-1) + 1*0.5 = 2.5; a second start arrives mid-RUN
    for (int k = 0; k < 4; k++) mem[16+k] = 24'd4096;
    mem[24] = 24'd4096; mem[25] = 24'd8192; mem[26] = 24'hFFF000; mem[27] = 24'd2048;
    run_op(5'd4, 6'd16, 6'd24, 6'd30, 1'b1);
    check("busy_start_we_cnt", we_cnt, 1);
    check("busy_start_waddr",  wa,     30);
    check("busy_start_wdata",  wd,     24'h002800);
    check("busy_start_lat",    lat,    6);

    // Reset during DRAIN: cycles after accept are RUN, RUN, DRAIN
    @(negedge clk);
    start = 1'b1; len = 5'd2; base_a = 6'd16; base_b = 6'd24; dst = 6'd33;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy,     0);
    check("mid_rst_we",   db_we,    0);
    check("mid_rst_done", done,     0);
    check("mid_rst_wd",   db_wdata, 0);
    rst_we = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 1) rst_n = 1'b1;
      if (db_we) rst_we++;
    end
    check("mid_rst_no_write", rst_we, 0);

    run_op(5'd2, 6'd16, 6'd24, 6'd34, 1'b0);
    check("post_rst_wdata", wd,     24'h003000);
    check("post_rst_waddr", wa,     34);
    check("post_rst_lat",   lat,    4);
    check("post_rst_we",    we_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
